cmd_issue_queue: RTL and testbench
==================================

Name: cmd_issue_queue

Overview:
- Sits directly downstream of the command scheduler and is the issue FIFO that the scheduler's isu_fifo_full / sch_issue handshake talks to.
- Buffers scheduled commands ({command, addr, bank}, `ISU_FIFO_WIDTH bits) and presents them in order to the DRAM command/PHY interface.
- Holds the head entry until the inter-command timing for its command class has expired (tRCD, tRP, tCCD, tRFC).

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- T_RCD, 4, minimum cycles from ACTIVE issue to READ/WRITE/RDA/WRA/PRECHARGE issue.
- T_RP, 4, minimum cycles from PRECHARGE issue to ACTIVE/REFRESH issue.
- T_CCD, 2, minimum cycles between column commands (READ/WRITE/RDA/WRA).
- T_RFC, 16, minimum cycles from REFRESH issue to ACTIVE/REFRESH issue.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- sch_issue  in  1  push request from the scheduler.
- sch_out  in  `ISU_FIFO_WIDTH  {sch_cmd_t command, `ADDR_BITS addr, `BA_BITS bank}.
- isu_fifo_full  out  1  FIFO full; the scheduler stalls on this signal.
- isu_fifo_empty  out  1  FIFO empty.
- isu_count  out  $clog2(DEPTH+1)  current occupancy.
- cmd_valid  out  1  head command is legal to issue.
- cmd_out  out  `ISU_FIFO_WIDTH  head entry.
- cmd_ready  in  1  PHY accepts cmd_out this cycle.
- isu_overflow  out  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset values: rst clears the pointers, count, all timers and isu_overflow immediately. Outputs during and after reset: isu_fifo_empty=1, isu_fifo_full=0, cmd_valid=0, cmd_out=0, isu_count=0.
- Reset in the middle of operation discards every queued entry and all pending timing.
- Push: accepted when sch_issue && !isu_fifo_full, where full is the registered count==DEPTH. A push while full is dropped and sets isu_overflow; the FIFO contents are unchanged.
- Pop: occurs when cmd_valid && cmd_ready. A push and a pop in the same cycle are both accepted when not full, and the count is unchanged.
- When full, a same-cycle pop does not unblock the push; the push is rejected that cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count saturates at neither end; over/underflow is prevented by the full and empty gating.
- Latency: an entry pushed into an empty FIFO appears on cmd_out the next cycle.
- Head gating: cmd_valid = !empty && legal(head). The legality rules per head command:
  - ACTIVE: rp_t==0 && rfc_t==0.
  - READ/WRITE/RDA/WRA: rcd_t==0 && ccd_t==0.
  - PRECHARGE: rcd_t==0.
  - REFRESH: rp_t==0 && rfc_t==0.
- NOP at head: discarded internally in one cycle without asserting cmd_valid and without loading any timer.
- Timer loads on an issued command:
  - ACTIVE: rcd_t=T_RCD-1.
  - PRECHARGE: rp_t=T_RP-1.
  - READ/WRITE: ccd_t=T_CCD-1.
  - RDA/WRA: ccd_t=T_CCD-1 and rp_t=T_RP+T_CCD-1.
  - REFRESH: rfc_t=T_RFC-1.
- Timer behaviour:
  - Each timer is 8 bits wide, decrements by 1 per cycle and saturates at 0.
  - A load takes precedence over the decrement.
  - With parameter value 1, the load is 0 and there is no stall.
- cmd_out is stable while cmd_valid=1 && cmd_ready=0. The head never changes until it is popped.

Optional Feature:
- Macro: ISU_BYPASS_EN.
- When defined: if the FIFO is empty, sch_issue=1, the incoming command is legal, and cmd_ready=1, the command is driven on cmd_out with cmd_valid=1 in the same cycle. It is not written into the FIFO, its timers load as for a normal pop, and isu_count is unchanged.
- When the bypass conditions fail, the command is pushed normally.
- When not defined: there is no combinational path from sch_issue/sch_out to cmd_valid/cmd_out, and minimum latency is 1 cycle.

Decomposition:
- Package usertype gains isu_entry_t (packed struct {sch_cmd_t cmd; addr; bank}) matching the scheduler's sch_out ordering.
- define.sv keeps `ISU_FIFO_WIDTH, `ADDR_BITS and `BA_BITS. Default timing values are added there as `T_RCD_DEF and similar.
- One sub-module: isu_timing_gate.
  - Contains the four timers and the legality decode.
  - Input: head cmd and an issue strobe. Output: legal.
- The FIFO storage and pointers stay in cmd_issue_queue.

Test Plan:
- Reset, then push ACTIVE b0 followed by READ → ACTIVE valid at cycle 1 and issued. READ is held with cmd_valid=0 for 3 cycles, then issued exactly 4 cycles after ACTIVE.
- Push 8 entries with cmd_ready=0 → isu_fifo_full=1, isu_count=8. A 9th push sets isu_overflow=1 and contents are unchanged. Then raise cmd_ready → entries drain in push order.
- Full FIFO with simultaneous push and pop → pop accepted, push rejected, isu_count=7.
- Back-to-back READ, READ, WRITE after tRCD is met → issues spaced 2 cycles apart (T_CCD).
- REFRESH then ACTIVE → ACTIVE issued 16 cycles after REFRESH. A NOP in the queue between them is consumed silently.
- Assert rst while 5 entries are queued and rcd_t is nonzero → immediately empty, cmd_valid=0, and the next ACTIVE is legal 1 cycle after it is pushed.

Source files
------------

// File: rtl/cmd_issue_queue_pkg.sv
// Shared types, widths and default DRAM timing for the command issue queue.
// Optional same-cycle bypass is enabled by defining ISU_BYPASS_EN.
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef CMD_BITS
`define CMD_BITS 3
`endif
`ifndef ISU_FIFO_WIDTH
`define ISU_FIFO_WIDTH (`CMD_BITS + `ADDR_BITS + `BA_BITS)
`endif
`ifndef T_RCD_DEF
`define T_RCD_DEF 4
`endif
`ifndef T_RP_DEF
`define T_RP_DEF 4
`endif
`ifndef T_CCD_DEF
`define T_CCD_DEF 2
`endif
`ifndef T_RFC_DEF
`define T_RFC_DEF 16
`endif

package cmd_issue_queue_pkg;

    localparam int ADDR_W = `ADDR_BITS;
    localparam int BA_W   = `BA_BITS;
    localparam int ISU_W  = `ISU_FIFO_WIDTH;

    typedef enum logic [`CMD_BITS-1:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_RDA = 3'd4,
        CMD_WRA = 3'd5,
        CMD_PRE = 3'd6,
        CMD_REF = 3'd7
    } sch_cmd_t;

    // Field order matches the scheduler's sch_out packing.
    typedef struct packed {
        sch_cmd_t          cmd;
        logic [ADDR_W-1:0] addr;
        logic [BA_W-1:0]   bank;
    } isu_entry_t;

    function automatic logic [7:0] ld_val(input int t);
        return (t > 1) ? 8'(t - 1) : 8'd0;
    endfunction

    function automatic logic [7:0] sat_dec(input logic [7:0] v);
        return (v == 8'd0) ? v : v - 8'd1;
    endfunction

endpackage

// File: rtl/cmd_issue_queue_if.sv
// Scheduler-facing push port and PHY-facing issue port of the issue queue.
// slave is the queue side, master is the scheduler/PHY side.
interface cmd_issue_queue_if #(
    parameter int DEPTH = 8
);
    import cmd_issue_queue_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic             sch_issue;
    logic [ISU_W-1:0] sch_out;
    logic             isu_fifo_full;
    logic             isu_fifo_empty;
    logic [CW-1:0]    isu_count;
    logic             cmd_valid;
    logic [ISU_W-1:0] cmd_out;
    logic             cmd_ready;
    logic             isu_overflow;

    modport slave (
        input  sch_issue,
        input  sch_out,
        input  cmd_ready,
        output isu_fifo_full,
        output isu_fifo_empty,
        output isu_count,
        output cmd_valid,
        output cmd_out,
        output isu_overflow
    );

    modport master (
        output sch_issue,
        output sch_out,
        output cmd_ready,
        input  isu_fifo_full,
        input  isu_fifo_empty,
        input  isu_count,
        input  cmd_valid,
        input  cmd_out,
        input  isu_overflow
    );

endinterface

// File: rtl/isu_timing_gate.sv
// Inter-command timers (tRCD, tRP, tCCD, tRFC) and the head legality decode.
// Timers load T-1 on an issue strobe and otherwise count down to zero.
module isu_timing_gate
    import cmd_issue_queue_pkg::*;
#(
    parameter int T_RCD = `T_RCD_DEF,
    parameter int T_RP  = `T_RP_DEF,
    parameter int T_CCD = `T_CCD_DEF,
    parameter int T_RFC = `T_RFC_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  sch_cmd_t cmd_i,
    input  logic     issue_i,
    output logic     legal_o
);

    localparam logic [7:0] LD_RCD = ld_val(T_RCD);
    localparam logic [7:0] LD_RP  = ld_val(T_RP);
    localparam logic [7:0] LD_RPA = ld_val(T_RP + T_CCD);
    localparam logic [7:0] LD_CCD = ld_val(T_CCD);
    localparam logic [7:0] LD_RFC = ld_val(T_RFC);

    logic [7:0] rcd_q, rcd_d;
    logic [7:0] rp_q, rp_d;
    logic [7:0] ccd_q, ccd_d;
    logic [7:0] rfc_q, rfc_d;

    logic rcd_ok, rp_ok, ccd_ok, rfc_ok;

    assign rcd_ok = (rcd_q == 8'd0);
    assign rp_ok  = (rp_q == 8'd0);
    assign ccd_ok = (ccd_q == 8'd0);
    assign rfc_ok = (rfc_q == 8'd0);

    always_comb begin
        legal_o = 1'b0;
        unique case (cmd_i)
            CMD_ACT, CMD_REF:
                legal_o = rp_ok && rfc_ok;
            CMD_RD, CMD_WR, CMD_RDA, CMD_WRA:
                legal_o = rcd_ok && ccd_ok;
            CMD_PRE:
                legal_o = rcd_ok;
            default:
                legal_o = 1'b0;
        endcase
    end

    // A load on issue overrides the decrement of that timer only.
    always_comb begin
        rcd_d = sat_dec(rcd_q);
        rp_d  = sat_dec(rp_q);
        ccd_d = sat_dec(ccd_q);
        rfc_d = sat_dec(rfc_q);
        if (issue_i) begin
            unique case (cmd_i)
                CMD_ACT: rcd_d = LD_RCD;
                CMD_PRE: rp_d  = LD_RP;
                CMD_RD, CMD_WR: ccd_d = LD_CCD;
                CMD_RDA, CMD_WRA: begin
                    ccd_d = LD_CCD;
                    rp_d  = LD_RPA;
                end
                CMD_REF: rfc_d = LD_RFC;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcd_q <= 8'd0;
            rp_q  <= 8'd0;
            ccd_q <= 8'd0;
            rfc_q <= 8'd0;
        end else begin
            rcd_q <= rcd_d;
            rp_q  <= rp_d;
            ccd_q <= ccd_d;
            rfc_q <= rfc_d;
        end
    end

endmodule

// File: rtl/cmd_issue_queue.sv
// In-order issue FIFO between the command scheduler and the DRAM PHY.
// Head is held until its timing class is legal; ISU_BYPASS_EN adds a bypass.
module cmd_issue_queue
    import cmd_issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int T_RCD = `T_RCD_DEF,
    parameter int T_RP  = `T_RP_DEF,
    parameter int T_CCD = `T_CCD_DEF,
    parameter int T_RFC = `T_RFC_DEF
) (
    input  logic clk,
    input  logic rst,
    cmd_issue_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    isu_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    isu_entry_t in_e;
    isu_entry_t head;
    isu_entry_t out_e;
    sch_cmd_t   chk_cmd;
    logic       empty;
    logic       full;
    logic       legal;
    logic       head_nop;
    logic       head_ok;
    logic       byp;
    logic       push;
    logic       pop;
    logic       issue;

    assign in_e     = isu_entry_t'(bus.sch_out);
    assign head     = mem_q[rd_q];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign head_nop = !empty && (head.cmd == CMD_NOP);

`ifdef ISU_BYPASS_EN
    // With nothing queued, legality is judged on the incoming command.
    assign chk_cmd = empty ? in_e.cmd : head.cmd;
    assign byp     = empty && bus.sch_issue
                  && legal && bus.cmd_ready;
`else
    assign chk_cmd = head.cmd;
    assign byp     = 1'b0;
`endif

    isu_timing_gate #(
        .T_RCD (T_RCD),
        .T_RP  (T_RP),
        .T_CCD (T_CCD),
        .T_RFC (T_RFC)
    ) u_gate (
        .clk     (clk),
        .rst     (rst),
        .cmd_i   (chk_cmd),
        .issue_i (issue),
        .legal_o (legal)
    );

    assign head_ok = !empty && legal;
    assign issue   = (head_ok && bus.cmd_ready) || byp;
    assign pop     = (head_ok && bus.cmd_ready) || head_nop;
    assign push    = bus.sch_issue && !full && !byp;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q || (bus.sch_issue && full);
        if (push) wr_d = wr_q + PW'(1);
        if (pop)  rd_d = rd_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: it is only observed through count-gated reads.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_e;
    end

    always_comb begin
        out_e = '0;
        if (byp)         out_e = in_e;
        else if (!empty) out_e = head;
    end

    assign bus.isu_fifo_full  = full;
    assign bus.isu_fifo_empty = empty;
    assign bus.isu_count      = cnt_q;
    assign bus.cmd_valid      = head_ok || byp;
    assign bus.cmd_out        = out_e;
    assign bus.isu_overflow   = ovf_q;

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Scoreboard bench for cmd_issue_queue: timing-rule reference model,
// directed scenarios followed by randomized push/ready traffic.
module tb_cmd_issue_queue;
    import cmd_issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_CCD = 2;
    localparam int T_RFC = 16;
    localparam int NEVER = 32'h7fffffff;

    typedef struct {
        isu_entry_t e;
        int         avail;
    } mq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    cmd_issue_queue_if #(.DEPTH(DEPTH)) bus();

    cmd_issue_queue #(
        .DEPTH (DEPTH),
        .T_RCD (T_RCD),
        .T_RP  (T_RP),
        .T_CCD (T_CCD),
        .T_RFC (T_RFC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mq_t      q[$];
    int       rcd_free = 0;
    int       rp_free  = 0;
    int       ccd_free = 0;
    int       rfc_free = 0;
    int       ovf_at   = NEVER;
    sch_cmd_t dlog_cmd[$];
    int       dlog_cyc[$];
    int       errors = 0;
    int       checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // A command is legal at cycle k once every constraining window ended.
    function automatic bit legal_at(input sch_cmd_t c, input int k);
        case (c)
            CMD_ACT, CMD_REF: return k >= rp_free && k >= rfc_free;
            CMD_RD, CMD_WR, CMD_RDA, CMD_WRA:
                return k >= rcd_free && k >= ccd_free;
            CMD_PRE: return k >= rcd_free;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_issue(input sch_cmd_t c, input int k);
        case (c)
            CMD_ACT: rcd_free = k + T_RCD;
            CMD_PRE: rp_free  = k + T_RP;
            CMD_RD, CMD_WR: ccd_free = k + T_CCD;
            CMD_RDA, CMD_WRA: begin
                ccd_free = k + T_CCD;
                rp_free  = k + T_RP + T_CCD;
            end
            CMD_REF: rfc_free = k + T_RFC;
            default: ;
        endcase
    endfunction

    always @(negedge clk) begin
        int  vis;
        bit  exp_v;
        if (rst) begin
            chk("rst_empty", 32'(bus.isu_fifo_empty), 1);
            chk("rst_full",  32'(bus.isu_fifo_full), 0);
            chk("rst_valid", 32'(bus.cmd_valid), 0);
            chk("rst_out",   32'(bus.cmd_out), 0);
            chk("rst_count", 32'(bus.isu_count), 0);
            chk("rst_ovf",   32'(bus.isu_overflow), 0);
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                isu_entry_t o;
                o = isu_entry_t'(bus.cmd_out);
                dlog_cmd.push_back(o.cmd);
                dlog_cyc.push_back(cyc);
            end
            vis = 0;
            foreach (q[i]) if (q[i].avail <= cyc) vis++;
            chk("count", 32'(bus.isu_count), vis);
            chk("empty", 32'(bus.isu_fifo_empty), 32'(vis == 0));
            chk("full",  32'(bus.isu_fifo_full), 32'(vis == DEPTH));
            chk("overflow", 32'(bus.isu_overflow), 32'(ovf_at <= cyc));
            if (vis == 0) begin
                chk("valid_empty", 32'(bus.cmd_valid), 0);
                chk("out_empty", 32'(bus.cmd_out), 0);
            end else begin
                chk("head", 32'(bus.cmd_out), 32'(q[0].e));
                if (q[0].e.cmd == CMD_NOP) begin
                    chk("valid_nop", 32'(bus.cmd_valid), 0);
                    void'(q.pop_front());
                end else begin
                    exp_v = legal_at(q[0].e.cmd, cyc);
                    chk("valid", 32'(bus.cmd_valid), 32'(exp_v));
                    if (exp_v && bus.cmd_ready) begin
                        model_issue(q[0].e.cmd, cyc);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input bit iss, input isu_entry_t ent,
                        input bit rdy);
        @(posedge clk);
        #1;
        bus.sch_issue = iss;
        bus.sch_out   = ent;
        bus.cmd_ready = rdy;
        if (iss) begin
            if (q.size() < DEPTH) q.push_back('{e: ent, avail: cyc + 1});
            else if (ovf_at == NEVER) ovf_at = cyc + 1;
        end
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.sch_issue = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.sch_out   = '0;
        q.delete();
        rcd_free = 0;
        rp_free  = 0;
        ccd_free = 0;
        rfc_free = 0;
        ovf_at   = NEVER;
        #1;
        chk("rst_now_empty", 32'(bus.isu_fifo_empty), 1);
        chk("rst_now_valid", 32'(bus.cmd_valid), 0);
        chk("rst_now_count", 32'(bus.isu_count), 0);
        repeat (hold) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, '0, rdy);
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((q.size() != 0 || !bus.isu_fifo_empty) && n < budget) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        chk(nm, 32'(bus.isu_fifo_empty), 1);
    endtask

    task automatic log_gap(input string nm, input int i, input int gap);
        if (i < 1 || i >= dlog_cyc.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: issue #%0d missing, log size %0d",
                     nm, i, dlog_cyc.size());
        end else begin
            chk(nm, dlog_cyc[i] - dlog_cyc[i-1], gap);
        end
    endtask

    task automatic log_cmd(input string nm, input int i, input sch_cmd_t c);
        if (i >= dlog_cmd.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: issue #%0d missing, log size %0d",
                     nm, i, dlog_cmd.size());
        end else begin
            chk(nm, 32'(dlog_cmd[i]), 32'(c));
        end
    endtask

    function automatic isu_entry_t mk(input sch_cmd_t c, input int b);
        isu_entry_t e;
        e.cmd  = c;
        e.addr = ADDR_W'($urandom);
        e.bank = BA_W'(b);
        return e;
    endfunction

    function automatic isu_entry_t rnd(input bit no_nop);
        return mk(sch_cmd_t'(no_nop ? $urandom_range(1, 7)
                                    : $urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
    endfunction

    initial begin
        int base;
        int pc;
        bus.sch_issue = 1'b0;
        bus.sch_out   = '0;
        bus.cmd_ready = 1'b0;
        do_reset(3);

        // ACTIVE then READ: READ waits out tRCD.
        base = dlog_cyc.size();
        step(1'b1, mk(CMD_ACT, 0), 1'b1);
        pc = cyc;
        step(1'b1, mk(CMD_RD, 0), 1'b1);
        drain("drain_p1", 50);
        log_cmd("p1_act", base, CMD_ACT);
        log_cmd("p1_rd", base + 1, CMD_RD);
        if (dlog_cyc.size() > base)
            chk("p1_act_lat", dlog_cyc[base] - pc, 1);
        log_gap("p1_trcd", base + 1, T_RCD);

        // Fill to full, overflow push, then full push+pop.
        idle(20, 1'b0);
        repeat (DEPTH) step(1'b1, rnd(1'b1), 1'b0);
        step(1'b1, rnd(1'b1), 1'b0);
        idle(20, 1'b0);
        @(negedge clk);
        chk("p2_full", 32'(bus.isu_fifo_full), 1);
        chk("p2_count8", 32'(bus.isu_count), DEPTH);
        chk("p2_ovf", 32'(bus.isu_overflow), 1);
        step(1'b1, rnd(1'b1), 1'b1);
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("p2_count7", 32'(bus.isu_count), DEPTH - 1);
        drain("drain_p2", 200);

        // Column commands spaced by tCCD.
        idle(20, 1'b1);
        base = dlog_cyc.size();
        step(1'b1, mk(CMD_ACT, 1), 1'b1);
        step(1'b1, mk(CMD_RD, 1), 1'b1);
        step(1'b1, mk(CMD_RD, 1), 1'b1);
        step(1'b1, mk(CMD_WR, 1), 1'b1);
        drain("drain_p3", 50);
        log_gap("p3_trcd", base + 1, T_RCD);
        log_gap("p3_tccd1", base + 2, T_CCD);
        log_gap("p3_tccd2", base + 3, T_CCD);
        log_cmd("p3_wr", base + 3, CMD_WR);

        // REFRESH, NOP, ACTIVE: NOP is silent, ACTIVE waits tRFC.
        idle(20, 1'b1);
        base = dlog_cyc.size();
        step(1'b1, mk(CMD_REF, 0), 1'b1);
        step(1'b1, mk(CMD_NOP, 0), 1'b1);
        step(1'b1, mk(CMD_ACT, 2), 1'b1);
        drain("drain_p4", 60);
        chk("p4_issues", dlog_cyc.size() - base, 2);
        log_cmd("p4_act", base + 1, CMD_ACT);
        log_gap("p4_trfc", base + 1, T_RFC);

        // Reset with entries queued and tRCD pending.
        idle(20, 1'b0);
        step(1'b1, mk(CMD_ACT, 3), 1'b0);
        repeat (5) step(1'b1, mk(CMD_RD, 3), 1'b0);
        step(1'b0, '0, 1'b1);
        do_reset(1);
        base = dlog_cyc.size();
        step(1'b1, mk(CMD_ACT, 4), 1'b1);
        pc = cyc;
        drain("drain_p5", 20);
        if (dlog_cyc.size() > base)
            chk("p5_act_lat", dlog_cyc[base] - pc, 1);
        else
            log_cmd("p5_act", base, CMD_ACT);

        // Random traffic with occasional reset.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1);
            else step($urandom_range(0, 99) < 55, rnd(1'b0),
                      $urandom_range(0, 99) < 70);
        end
        drain("drain_rand", 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
